miriscv_imem_responder: RTL and testbench



---
 rtl/miriscv_pkg.sv | 18 +
 rtl/miriscv_imem_delay_line.sv | 48 ++++
 rtl/miriscv_imem_responder.sv | 149 ++++++++++++++
 tb/tb_miriscv_imem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// Shared core definitions: datapath width, the canonical NOP encoding and the
// instruction-memory response record carried through the read pipeline.
package miriscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- also the fetch unit's bubble instruction.
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  localparam int IMEM_MAX_LATENCY = 4;

  typedef struct packed {
    logic            valid;
    logic            err;
    logic [XLEN-1:0] data;
  } imem_resp_t;

endpackage

// File: rtl/miriscv_imem_delay_line.sv
// Fixed-depth shift line for instruction-memory responses. Only the valid bits
// are reset; error/data stages are plain registers that follow their input.
module miriscv_imem_delay_line
  import miriscv_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  imem_resp_t resp_i,
  output imem_resp_t resp_o
);

  if (STAGES == 0) begin : g_bypass
    assign resp_o = resp_i;

    logic w_unused;
    assign w_unused = &{1'b0, clk_i, rst_i};
  end else begin : g_line
    logic            r_valid [STAGES];
    logic            r_err   [STAGES];
    logic [XLEN-1:0] r_data  [STAGES];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < STAGES; i++) r_valid[i] <= 1'b0;
      end else begin
        r_valid[0] <= resp_i.valid;
        for (int i = 1; i < STAGES; i++) r_valid[i] <= r_valid[i-1];
      end
    end

    // Payload carries no reset so it maps onto plain flops without reset muxing.
    always_ff @(posedge clk_i) begin
      r_err[0]  <= resp_i.err;
      r_data[0] <= resp_i.data;
      for (int i = 1; i < STAGES; i++) begin
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end

    assign resp_o.valid = r_valid[STAGES-1];
    assign resp_o.err   = r_err[STAGES-1];
    assign resp_o.data  = r_data[STAGES-1];
  end

endmodule

// File: rtl/miriscv_imem_responder.sv
// Instruction-memory responder: word RAM, side-band program load port and a
// LATENCY-deep read pipeline. Optional error reporting under MIRISCV_IMEM_ERR_EN.
module miriscv_imem_responder
  import miriscv_pkg::*;
#(
  parameter int unsigned     DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int              LATENCY   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_req_o_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
  input  logic            load_we_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic [XLEN-1:0] load_data_i,
  output logic            load_busy_o
`ifdef MIRISCV_IMEM_ERR_EN
  ,
  output logic            instr_err_o,
  output logic [15:0]     err_cnt_o
`endif
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH * 4);

  if (LATENCY < 1 || LATENCY > IMEM_MAX_LATENCY) begin : g_bad_latency
    $error("miriscv_imem_responder: LATENCY must be in 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("miriscv_imem_responder: DEPTH must be a power of two");
  end
  if ((BASE_ADDR & (SPAN - 1)) != '0) begin : g_bad_base
    $error("miriscv_imem_responder: BASE_ADDR must be DEPTH*4 aligned");
  end

  // Unsigned offset compare also rejects addresses below BASE_ADDR via wrap-around.
  logic [XLEN-1:0] w_fetch_off;
  logic            w_fetch_in_range;
  logic [AW-1:0]   w_fetch_idx;
  logic            w_fetch_err;
  logic [XLEN-1:0] w_load_off;
  logic            w_load_in_range;
  logic [AW-1:0]   w_load_idx;

  assign w_fetch_off      = instr_addr_i - BASE_ADDR;
  assign w_fetch_in_range = (w_fetch_off < SPAN);
  assign w_fetch_idx      = w_fetch_off[AW+1:2];
  assign w_load_off       = load_addr_i - BASE_ADDR;
  assign w_load_in_range  = (w_load_off < SPAN);
  assign w_load_idx       = w_load_off[AW+1:2];

`ifdef MIRISCV_IMEM_ERR_EN
  assign w_fetch_err = !w_fetch_in_range || (instr_addr_i[1:0] != 2'b00);
`else
  assign w_fetch_err = 1'b0;
`endif

  logic [XLEN-1:0] r_mem [DEPTH];

  // NOTE: memory arrays are never reset; a reset loop would turn the RAM into flops.
  always_ff @(posedge clk_i) begin
    if (load_we_i && w_load_in_range) r_mem[w_load_idx] <= load_data_i;
  end

  logic            r_s0_valid;
  logic            r_s0_err;
  logic            r_s0_oor;
  logic [XLEN-1:0] r_s0_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_s0_valid <= 1'b0;
    else       r_s0_valid <= instr_req_o_i;
  end

  // NOTE: non-blocking read of r_mem samples the pre-edge contents, which is
  // what gives read-first behaviour when a load write hits the same word.
  always_ff @(posedge clk_i) begin
    if (instr_req_o_i) begin
      r_s0_rdata <= r_mem[w_fetch_idx];
      r_s0_err   <= w_fetch_err;
      r_s0_oor   <= !w_fetch_in_range;
    end
  end

  imem_resp_t w_s0_resp;
  imem_resp_t w_out_resp;

  assign w_s0_resp.valid = r_s0_valid;
  assign w_s0_resp.err   = r_s0_err;
  assign w_s0_resp.data  = r_s0_oor ? RV_NOP : r_s0_rdata;

  miriscv_imem_delay_line #(
    .STAGES (LATENCY - 1)
  ) u_delay_line (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .resp_i (w_s0_resp),
    .resp_o (w_out_resp)
  );

  logic [XLEN-1:0] w_out_data;
  logic [XLEN-1:0] r_last_data;

  assign w_out_data = w_out_resp.err ? RV_NOP : w_out_resp.data;

  // Output mux, not an extra register, so the hold costs no latency.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 r_last_data <= '0;
    else if (w_out_resp.valid) r_last_data <= w_out_data;
  end

  assign instr_rvalid_o = w_out_resp.valid;
  assign instr_rdata_o  = w_out_resp.valid ? w_out_data : r_last_data;

  logic r_load_we_q;
  logic r_load_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_load_we_q <= 1'b0;
      r_load_busy <= 1'b0;
    end else begin
      r_load_we_q <= load_we_i;
      r_load_busy <= load_we_i | r_load_we_q;
    end
  end

  assign load_busy_o = r_load_busy;

`ifdef MIRISCV_IMEM_ERR_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (w_out_resp.valid && w_out_resp.err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign instr_err_o = w_out_resp.valid & w_out_resp.err;
  assign err_cnt_o   = r_err_cnt;
`endif

endmodule

// File: tb/tb_miriscv_imem_responder.sv
// Directed bench for miriscv_imem_responder: three instances (LATENCY 1, 3, 4)
// share the stimulus; each scenario checks the instance it targets.
module tb_miriscv_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rv1, rv3, rv4;
  logic [31:0] rd1, rd3, rd4;
  logic        busy1, busy3, busy4;
`ifdef MIRISCV_IMEM_ERR_EN
  logic        err1, err3, err4;
  logic [15:0] cnt1, cnt3, cnt4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  miriscv_imem_responder #(.LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .instr_req_o_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rv1), .instr_rdata_o(rd1),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_busy_o(busy1)
`ifdef MIRISCV_IMEM_ERR_EN
    , .instr_err_o(err1), .err_cnt_o(cnt1)
`endif
  );

  miriscv_imem_responder #(.LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .instr_req_o_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rv3), .instr_rdata_o(rd3),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_busy_o(busy3)
`ifdef MIRISCV_IMEM_ERR_EN
    , .instr_err_o(err3), .err_cnt_o(cnt3)
`endif
  );

  miriscv_imem_responder #(.LATENCY(4)) u_lat4 (
    .clk_i(clk), .rst_i(rst), .instr_req_o_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rv4), .instr_rdata_o(rd4),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_busy_o(busy4)
`ifdef MIRISCV_IMEM_ERR_EN
    , .instr_err_o(err4), .err_cnt_o(cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int busy_cycles;

    rst = 1'b1; req = 1'b0; addr = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    idle(2);
    check("rst_rvalid1", rv1, 1'b0);
    check("rst_rdata1",  rd1, 32'h0);
    check("rst_busy1",   busy1, 1'b0);
    check("rst_rvalid4", rv4, 1'b0);
`ifdef MIRISCV_IMEM_ERR_EN
    check("rst_errcnt1", cnt1, 16'd0);
`endif
    rst = 1'b0;
    tick();

    // Program image: word i = A000_0000 + i.
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = 32'(i * 4); load_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    load_we = 1'b0;
    idle(3);

    // Out-of-range write must be dropped rather than alias onto word 0.
    load_we = 1'b1; load_addr = 32'h0000_1000; load_data = 32'hBADC_0DE0;
    tick();
    load_we = 1'b0;
    idle(3);

    // LATENCY=1 back-to-back.
    req = 1'b1; addr = 32'h0;
    tick();
    check("l1_rv0", rv1, 1'b1);
    check("l1_rd0", rd1, 32'hA000_0000);
    addr = 32'h4;
    tick();
    check("l1_rv1", rv1, 1'b1);
    check("l1_rd1", rd1, 32'hA000_0001);
    addr = 32'h8;
    tick();
    check("l1_rd2", rd1, 32'hA000_0002);
`ifdef MIRISCV_IMEM_ERR_EN
    check("l1_err_ok", err1, 1'b0);
`endif
    req = 1'b0;
    tick();
    check("l1_rv_idle", rv1, 1'b0);
    check("l1_hold",    rd1, 32'hA000_0002);
    idle(6);

    // LATENCY=3 single request then idle.
    req = 1'b1; addr = 32'h10;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("l3_rv_c%0d", k), rv3, (k == 3) ? 1'b1 : 1'b0);
      if (k >= 3) check($sformatf("l3_rd_c%0d", k), rd3, 32'hA000_0004);
      tick();
    end
    idle(4);

    // One past the last word.
    req = 1'b1; addr = 32'h0000_1000;
    tick();
    req = 1'b0;
    check("oor_rv", rv1, 1'b1);
    check("oor_rd", rd1, 32'h0000_0013);
`ifdef MIRISCV_IMEM_ERR_EN
    check("oor_err", err1, 1'b1);
`endif
    tick();
    check("oor_rv_once", rv1, 1'b0);
`ifdef MIRISCV_IMEM_ERR_EN
    check("oor_cnt", cnt1, 16'd1);
`endif

    // Misaligned fetch inside word 1.
    req = 1'b1; addr = 32'h6;
    tick();
    req = 1'b0;
`ifdef MIRISCV_IMEM_ERR_EN
    check("mis_err", err1, 1'b1);
    check("mis_rd",  rd1, 32'h0000_0013);
    tick();
    check("mis_cnt", cnt1, 16'd2);
`else
    check("mis_rd",  rd1, 32'hA000_0001);
    tick();
`endif

    req = 1'b1; addr = 32'h0;
    tick();
    req = 1'b0;
    check("oor_load_dropped", rd1, 32'hA000_0000);
    tick();

    // Read-first collision on word 8.
    load_we = 1'b1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF;
    req = 1'b1; addr = 32'h20;
    tick();
    load_we = 1'b0;
    check("coll_old", rd1, 32'hA000_0008);
    tick();
    check("coll_new", rd1, 32'hDEAD_BEEF);
    req = 1'b0;
    idle(6);

    // LATENCY=4: three in flight, reset pulse (with a req that must be ignored).
    req = 1'b1; addr = 32'h0;
    tick();
    addr = 32'h4;
    tick();
    addr = 32'h8;
    tick();
    addr = 32'hC; rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    check("l4_rst_rv", rv4, 1'b0);
    check("l4_rst_rd", rd4, 32'h0);
    check("l1_rst_rv", rv1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("l4_flush_c%0d", k), rv4, 1'b0);
    end
    req = 1'b1; addr = 32'h0;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("l4_rv_c%0d", k), rv4, (k == 4) ? 1'b1 : 1'b0);
      if (k == 4) check("l4_rd", rd4, 32'hA000_0000);
      if (k < 4) tick();
    end
    idle(3);

    // Load burst of 8 and busy window.
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      load_we = 1'b1; load_addr = 32'h100 + 32'(i * 4); load_data = 32'h5500_0000 + 32'(i * 'h11);
      tick();
      if (busy1) busy_cycles++;
    end
    load_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy1) busy_cycles++;
    end
    check("busy_cycles", 32'(busy_cycles), 32'd9);
    check("busy_low", busy1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      req = 1'b1; addr = 32'h100 + 32'(i * 4);
      tick();
      check($sformatf("burst_rd%0d", i), rd1, 32'h5500_0000 + 32'(i * 'h11));
    end
    req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
